// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: op encodings, size classes,
// FSM state encoding and op classification helpers.
package mau_pkg;

    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_LWU = 4'h6;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_SD  = 4'hB;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    // Bit 3 splits the code space into load and store classes, undefined codes included.
    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return ~op[3];
    endfunction

    function automatic size_t size_of(input logic [3:0] op);
        return size_t'(op[1:0]);
    endfunction

    function automatic logic is_defined(input logic [3:0] op, input logic wide);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            OP_LD, OP_LWU, OP_SD: return wide;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Lane select plus sign/zero extension of a bus read word into a register value.
module load_extender #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           raw,
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [1:0]                  size,
    input  logic                        is_unsigned,
    output logic [DATA_W-1:0]           result
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word_ext;

    assign shifted = raw >> {off, 3'b000};

    // A word already fills a 32-bit register, so there is nothing to extend there.
    if (DATA_W > 32) begin : g_wide
        assign word_ext = {{(DATA_W-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
    end else begin : g_narrow
        assign word_ext = shifted;
    end

    always_comb begin
        result = shifted;
        case (size)
            2'd0: result = {{(DATA_W-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            2'd1: result = {{(DATA_W-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            2'd2: result = word_ext;
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, req/ack bus access with byte
// enables and replicated store data, extended load return and pipeline stall.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [3:0]          op_code,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                exc_adel,
    output logic                exc_ades,
    output logic                exc_bus,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err
);
    localparam int   BE_W  = DATA_W / 8;
    localparam int   OFF_W = $clog2(BE_W);
    localparam int   CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic WIDE  = (DATA_W == 64);

    state_t            state_reg;
    logic [3:0]        op_reg;
    logic [OFF_W-1:0]  off_reg;
    logic              flushed_reg;
    logic [CNT_W-1:0]  cnt_reg;

    size_t             in_size;
    logic              in_misaligned;
    logic [BE_W-1:0]   in_be;
    logic [DATA_W-1:0] in_rep;
    logic [DATA_W-1:0] ext_data;
    logic              accept;
    logic              timed_out;
    logic              discard;

    assign in_size   = size_of(op_code);
    assign accept    = (state_reg != ST_REQ) && op_valid && !flush;
    assign timed_out = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign discard   = flushed_reg || flush;

    always_comb begin
        in_misaligned = 1'b0;
        in_be         = '1;
        case (in_size)
            SZ_B: in_be = BE_W'(1) << addr[OFF_W-1:0];
            SZ_H: begin
                in_misaligned = addr[0];
                in_be         = BE_W'(2'b11) << addr[OFF_W-1:0];
            end
            SZ_W: begin
                in_misaligned = |addr[1:0];
                in_be         = BE_W'(4'hF) << addr[OFF_W-1:0];
            end
            default: in_misaligned = |addr[2:0];
        endcase
    end

    // Each lane takes the byte of the store operand that lands there after replication.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        assign in_rep[gi*8 +: 8] = (in_size == SZ_B) ? wdata[7:0] :
                                   (in_size == SZ_H) ? wdata[(gi % 2)*8 +: 8] :
                                   (in_size == SZ_W) ? wdata[(gi % 4)*8 +: 8] :
                                                       wdata[gi*8 +: 8];
    end

    load_extender #(.DATA_W(DATA_W)) u_load_extender (
        .raw         (bus_rdata),
        .off         (off_reg),
        .size        (op_reg[1:0]),
        .is_unsigned (op_reg[2]),
        .result      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            off_reg     <= '0;
            flushed_reg <= 1'b0;
            cnt_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            exc_bus     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    state_reg <= ST_IDLE;
                    if (accept) begin
                        op_reg      <= op_code;
                        off_reg     <= addr[OFF_W-1:0];
                        flushed_reg <= 1'b0;
                        cnt_reg     <= '0;
                        if (in_misaligned || !is_defined(op_code, WIDE)) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            exc_adel  <= is_load(op_code);
                            exc_ades  <= is_store(op_code);
                            exc_bus   <= 1'b0;
                        end else begin
                            state_reg <= ST_REQ;
                            busy      <= 1'b1;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store(op_code);
                            bus_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_be    <= in_be;
                            bus_wdata <= in_rep;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack || timed_out) begin
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                        if (discard) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            exc_adel  <= 1'b0;
                            exc_ades  <= 1'b0;
                            exc_bus   <= bus_ack ? bus_err : 1'b1;
                            if (bus_ack && is_load(op_reg)) begin
                                rdata <= ext_data;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (flush) begin
                            flushed_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a 32-bit and a 64-bit unit driven by directed and random
// load/store ops, compared against a byte-arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        op_valid, flush, bus_ack, bus_err;
    logic [1:0][3:0]   op_code;
    logic [1:0][31:0]  addr;
    logic [1:0][63:0]  wdata, bus_rdata;
    wire  [1:0]        busy, done, exc_adel, exc_ades, exc_bus, bus_req, bus_we;
    wire  [1:0][31:0]  bus_addr;
    wire  [1:0][63:0]  rdata, bus_wdata;
    wire  [1:0][7:0]   bus_be;

    int checks = 0;
    int errors = 0;
    logic [63:0] m_rdata [2];
    logic        m_adel [2];
    logic        m_ades [2];
    logic        m_bus  [2];

    assign rdata[0][63:32]     = '0;
    assign bus_wdata[0][63:32] = '0;
    assign bus_be[0][7:4]      = '0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .reset(reset), .op_valid(op_valid[0]), .op_code(op_code[0]),
        .addr(addr[0]), .wdata(wdata[0][31:0]), .flush(flush[0]), .busy(busy[0]),
        .done(done[0]), .rdata(rdata[0][31:0]), .exc_adel(exc_adel[0]),
        .exc_ades(exc_ades[0]), .exc_bus(exc_bus[0]), .bus_req(bus_req[0]),
        .bus_we(bus_we[0]), .bus_addr(bus_addr[0]), .bus_be(bus_be[0][3:0]),
        .bus_wdata(bus_wdata[0][31:0]), .bus_ack(bus_ack[0]),
        .bus_rdata(bus_rdata[0][31:0]), .bus_err(bus_err[0])
    );

    mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .reset(reset), .op_valid(op_valid[1]), .op_code(op_code[1]),
        .addr(addr[1]), .wdata(wdata[1]), .flush(flush[1]), .busy(busy[1]),
        .done(done[1]), .rdata(rdata[1]), .exc_adel(exc_adel[1]),
        .exc_ades(exc_ades[1]), .exc_bus(exc_bus[1]), .bus_req(bus_req[1]),
        .bus_we(bus_we[1]), .bus_addr(bus_addr[1]), .bus_be(bus_be[1]),
        .bus_wdata(bus_wdata[1]), .bus_ack(bus_ack[1]),
        .bus_rdata(bus_rdata[1]), .bus_err(bus_err[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_op(input int u, input logic [3:0] c);
        if (c inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW}) return 1'b1;
        if (c inside {OP_LD, OP_LWU, OP_SD}) return (u == 1);
        return 1'b0;
    endfunction

    // Extract nb bytes starting at byte off, then sign/zero-extend to the bus width.
    function automatic logic [63:0] model_load(input int u, input logic [3:0] c,
                                               input int off, input logic [63:0] word);
        int nb = 1 << c[1:0];
        logic [63:0] v = word >> (off * 8);
        logic [63:0] mask;
        if (nb < 8) begin
            mask = (64'd1 << (nb * 8)) - 64'd1;
            v = v & mask;
            if ((c inside {OP_LB, OP_LH, OP_LW}) && v[nb*8-1]) v = v | ~mask;
        end
        return (u == 0) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    task automatic chk_status(input int u, input string tag, input logic exp_done);
        chk({tag, ".done"}, 64'(done[u]), 64'(exp_done));
        chk({tag, ".busy"}, 64'(busy[u]), 64'd0);
        chk({tag, ".req"}, 64'(bus_req[u]), 64'd0);
        chk({tag, ".flags"}, {61'd0, exc_adel[u], exc_ades[u], exc_bus[u]},
            {61'd0, m_adel[u], m_ades[u], m_bus[u]});
        chk({tag, ".rdata"}, rdata[u], m_rdata[u]);
    endtask

    // Starts and ends at a falling edge; ack_at<0 means the bus never acks.
    task automatic run_op(input int u, input logic [3:0] c, input logic [31:0] a,
                          input logic [63:0] wd, input int ack_at, input logic [63:0] brd,
                          input logic berr, input int flush_at);
        int dw = (u == 1) ? 64 : 32;
        int nb = 1 << c[1:0];
        int off = int'(a % (dw / 8));
        bit acked = 0;
        bit flushed = 0;
        logic [63:0] exp_wd = '0;
        logic [63:0] exp_be = ((64'd1 << nb) - 64'd1) << off;
        for (int i = 0; i < dw / (8 * nb); i++)
            exp_wd = exp_wd | ((wd & ((nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1))) << (i * nb * 8));
        op_valid[u] = 1'b1; op_code[u] = c; addr[u] = a; wdata[u] = wd;
        @(posedge clk); @(negedge clk);
        op_valid[u] = 1'b0;
        if (!legal_op(u, c) || (a % nb) != 0) begin
            m_adel[u] = (c < 4'h8); m_ades[u] = (c >= 4'h8); m_bus[u] = 1'b0;
            chk_status(u, "addr_exc", 1'b1);
        end else begin
            for (int k = 0; k < TMO; k++) begin
                chk("req.req", 64'(bus_req[u]), 64'd1);
                chk("req.busy", 64'(busy[u]), 64'd1);
                if (k == 0) begin
                    chk("req.we", 64'(bus_we[u]), 64'(c >= 4'h8));
                    chk("req.addr", 64'(bus_addr[u]), 64'(a & ~32'(dw / 8 - 1)));
                    chk("req.be", 64'(bus_be[u]), exp_be);
                    if (c >= 4'h8) chk("req.wdata", bus_wdata[u], exp_wd);
                end
                bus_ack[u] = (k == ack_at);
                bus_rdata[u] = (k == ack_at) ? brd : {$urandom, $urandom};
                bus_err[u] = berr && (k == ack_at);
                flush[u] = (k == flush_at);
                if (k == flush_at) flushed = 1;
                @(posedge clk); @(negedge clk);
                bus_ack[u] = 1'b0; bus_err[u] = 1'b0; flush[u] = 1'b0;
                if (k == ack_at) begin
                    acked = 1;
                    break;
                end
            end
            if (flushed) begin
                chk_status(u, "flushed", 1'b0);
            end else if (acked) begin
                m_adel[u] = 1'b0; m_ades[u] = 1'b0; m_bus[u] = berr;
                if (c < 4'h8) m_rdata[u] = model_load(u, c, off, brd);
                chk_status(u, "ack_done", 1'b1);
            end else begin
                m_adel[u] = 1'b0; m_ades[u] = 1'b0; m_bus[u] = 1'b1;
                chk_status(u, "timeout", 1'b1);
            end
        end
        $display("txn unit=%0d op=%h addr=%h ack_at=%0d flush_at=%0d rdata=%h",
                 u, c, a, ack_at, flush_at, rdata[u]);
    endtask

    task automatic idle_cycle(input int u);
        @(posedge clk); @(negedge clk);
        chk_status(u, "idle", 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        op_valid = '0; flush = '0; bus_ack = '0; bus_err = '0;
        op_code = '0; addr = '0; wdata = '0; bus_rdata = '0;
        for (int u = 0; u < 2; u++) begin
            m_rdata[u] = '0; m_adel[u] = 0; m_ades[u] = 0; m_bus[u] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk_status(u, "reset", 1'b0);
            chk("reset.bus", {bus_we[u], bus_addr[u], bus_be[u], 23'd0}, 64'd0);
            chk("reset.wdata", bus_wdata[u], 64'd0);
        end

        run_op(0, OP_LB, 32'h1003, 64'd0, 0, 64'h80FF_1234, 1'b0, -1);
        run_op(0, OP_SH, 32'h2002, 64'h0000_BEEF, 3, 64'd0, 1'b0, -1);
        run_op(0, OP_LW, 32'h3001, 64'd0, 0, 64'd0, 1'b0, -1);
        run_op(0, OP_SW, 32'h3002, 64'h1234_5678, 0, 64'd0, 1'b0, -1);
        run_op(0, OP_LHU, 32'h0010, 64'd0, -1, 64'd0, 1'b0, -1);
        idle_cycle(0);
        run_op(0, OP_LW, 32'h0020, 64'd0, 2, 64'hCAFE_F00D, 1'b0, 0);
        run_op(0, OP_LW, 32'h0024, 64'd0, 1, 64'h1357_9BDF, 1'b0, -1);
        run_op(1, OP_LWU, 32'h4004, 64'd0, 0, 64'h8765_4321_0000_0000, 1'b0, -1);
        run_op(0, OP_LWU, 32'h4004, 64'd0, 0, 64'd0, 1'b0, -1);
        run_op(1, OP_SB, 32'h5005, 64'h0000_00A5, 1, 64'd0, 1'b1, -1);
        idle_cycle(1);

        // Flush alongside a presented op must block acceptance.
        op_valid[0] = 1'b1; op_code[0] = OP_LW; addr[0] = 32'h40; flush[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        op_valid[0] = 1'b0; flush[0] = 1'b0;
        chk_status(0, "flush_idle", 1'b0);

        // Reset in the middle of a bus request.
        op_valid[1] = 1'b1; op_code[1] = OP_LD; addr[1] = 32'h80;
        @(posedge clk); @(negedge clk);
        op_valid[1] = 1'b0;
        chk("rst_req.req", 64'(bus_req[1]), 64'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_rdata[u] = '0; m_adel[u] = 0; m_ades[u] = 0; m_bus[u] = 0;
        end
        chk_status(1, "rst_req", 1'b0);

        for (int n = 0; n < 120; n++) begin
            int u = n % 2;
            logic [3:0] c = 4'($urandom_range(0, 15));
            logic [31:0] a = ($urandom & 32'hFFFF_FFF8) |
                             (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 7)) : 32'd0);
            int ack_at = int'($urandom_range(0, 4)) - 1;
            int flush_at = -1;
            if ($urandom_range(0, 4) == 0) begin
                ack_at = int'($urandom_range(0, 3));
                flush_at = int'($urandom_range(0, ack_at));
            end
            if ((c[1:0] != 2'd0) && ($urandom_range(0, 1) == 0)) a = a & 32'hFFFF_FFF8;
            run_op(u, c, a, {$urandom, $urandom}, ack_at, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), flush_at);
            if ($urandom_range(0, 1) == 0) idle_cycle(u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
